// File: rtl/onehot_decoder_seq_if.sv
// Request/response bundle for onehot_decoder_seq: decode requests in, registered one-hot vector out.
// The master drives requests and the slave (the decoder) drives the vector and status.
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 2**SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             sweep_start;
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic [SEL_W-1:0] out_index;
    logic             busy;
    logic             sweep_done;

    modport master (
        output in_valid, in_sel, sweep_start,
        input  in_ready, out_onehot, out_valid, out_index, busy, sweep_done
    );

    modport slave (
        input  in_valid, in_sel, sweep_start,
        output in_ready, out_onehot, out_valid, out_index, busy, sweep_done
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder; each vector is held PULSE_LEN cycles, plus an 0..OUT_W-1 sweep mode.
// Optional macro DECODER_ZERO_MASK_EN: index 0 yields an all-zero vector (x0 write protection).
module onehot_decoder_seq #(
    parameter int SEL_W     = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    onehot_decoder_seq_if.slave bus
);
    localparam int               OUT_W    = 2**SEL_W;
    localparam logic [7:0]       RELOAD   = 8'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SWEEP} state_t;

    state_t     state;
    logic [7:0] counter;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
`ifdef DECODER_ZERO_MASK_EN
        if (idx == '0) begin
            vec = '0;
        end
`endif
        return vec;
    endfunction

    // A pending sweep request wins over a decode, so it also withholds ready.
    assign bus.in_ready = rst_n && (state == IDLE) && !bus.sweep_start;
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            counter        <= '0;
            bus.out_onehot <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_index  <= '0;
            bus.sweep_done <= 1'b0;
        end else begin
            bus.sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sweep_start) begin
                        state          <= SWEEP;
                        counter        <= RELOAD;
                        bus.out_onehot <= decode('0);
                        bus.out_valid  <= 1'b1;
                        bus.out_index  <= '0;
                    end else if (bus.in_valid) begin
                        state          <= DRIVE;
                        counter        <= RELOAD;
                        bus.out_onehot <= decode(bus.in_sel);
                        bus.out_valid  <= 1'b1;
                        bus.out_index  <= bus.in_sel;
                    end
                end
                DRIVE: begin
                    if (counter == 8'd0) begin
                        state          <= IDLE;
                        bus.out_onehot <= '0;
                        bus.out_valid  <= 1'b0;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                SWEEP: begin
                    // Steps run back to back; the last index ends the sweep instead of wrapping.
                    if (counter == 8'd0) begin
                        if (bus.out_index == LAST_IDX) begin
                            state          <= IDLE;
                            bus.out_onehot <= '0;
                            bus.out_valid  <= 1'b0;
                            bus.sweep_done <= 1'b1;
                        end else begin
                            counter        <= RELOAD;
                            bus.out_onehot <= decode(bus.out_index + 1'b1);
                            bus.out_index  <= bus.out_index + 1'b1;
                        end
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (PULSE_LEN 1 and 3) share stimulus and are each
// compared cycle by cycle against a queue of the output vectors they are expected to emit.
module tb_onehot_decoder_seq;
    typedef struct packed {
        logic [15:0] oh;
        logic        valid;
        logic [3:0]  idx;
        logic        done;
    } entry_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       inValid = 1'b0;
    logic [3:0] inSel = '0;
    logic       sweepStart = 1'b0;
    int         checkCount = 0;
    int         errorCount = 0;
    entry_t     qA[$];
    entry_t     qB[$];

    onehot_decoder_seq_if #(.SEL_W(4)) busA ();
    onehot_decoder_seq_if #(.SEL_W(4)) busB ();

    assign busA.in_valid    = inValid;
    assign busA.in_sel      = inSel;
    assign busA.sweep_start = sweepStart;
    assign busB.in_valid    = inValid;
    assign busB.in_sel      = inSel;
    assign busB.sweep_start = sweepStart;

    onehot_decoder_seq #(.SEL_W(4), .PULSE_LEN(1)) dutA (.clk(clk), .rst_n(rstN), .bus(busA));
    onehot_decoder_seq #(.SEL_W(4), .PULSE_LEN(3)) dutB (.clk(clk), .rst_n(rstN), .bus(busB));

    always #5 clk = ~clk;

    function automatic logic [15:0] expOneHot(input int idx);
`ifdef DECODER_ZERO_MASK_EN
        if (idx == 0) return 16'h0000;
`endif
        return 16'(1) << idx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Head of the queue is what should be on the outputs this cycle; an empty queue means idle zeros.
    task automatic checkDut(input string name, ref entry_t q[$], input logic [15:0] oh,
                            input logic valid, input logic [3:0] idx, input logic done, input logic busy);
        entry_t e;
        e = '0;
        if (q.size() != 0) e = q[0];
        checkOutput({name, ".onehot"}, 32'(oh), 32'(e.oh));
        checkOutput({name, ".valid"}, 32'(valid), 32'(e.valid));
        checkOutput({name, ".sweep_done"}, 32'(done), 32'(e.done));
        checkOutput({name, ".busy"}, 32'(busy), 32'((q.size() != 0) && !e.done));
        if (e.valid) checkOutput({name, ".index"}, 32'(idx), 32'(e.idx));
    endtask

    function automatic logic idleOf(ref entry_t q[$]);
        return (q.size() == 0) || q[0].done;
    endfunction

    task automatic stepModel(input int plen, ref entry_t q[$]);
        logic   idle;
        entry_t e;
        idle = idleOf(q);
        if (q.size() != 0) void'(q.pop_front());
        if (!rstN) begin
            q.delete();
        end else if (idle && sweepStart) begin
            for (int i = 0; i < 16; i++) begin
                for (int k = 0; k < plen; k++) begin
                    e.oh = expOneHot(i); e.valid = 1'b1; e.idx = 4'(i); e.done = 1'b0;
                    q.push_back(e);
                end
            end
            e = '0;
            e.done = 1'b1;
            q.push_back(e);
        end else if (idle && inValid) begin
            for (int k = 0; k < plen; k++) begin
                e.oh = expOneHot(int'(inSel)); e.valid = 1'b1; e.idx = inSel; e.done = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] s, input logic sw);
        @(negedge clk);
        checkDut("A", qA, busA.out_onehot, busA.out_valid, busA.out_index, busA.sweep_done, busA.busy);
        checkDut("B", qB, busB.out_onehot, busB.out_valid, busB.out_index, busB.sweep_done, busB.busy);
        rstN = r; inValid = v; inSel = s; sweepStart = sw;
        #1;
        checkOutput("A.in_ready", 32'(busA.in_ready), 32'(rstN && idleOf(qA) && !sweepStart));
        checkOutput("B.in_ready", 32'(busB.in_ready), 32'(rstN && idleOf(qB) && !sweepStart));
        @(posedge clk);
        stepModel(1, qA);
        stepModel(3, qB);
    endtask

    initial begin
        rstN = 1'b0; inValid = 1'b1; inSel = 4'd5; sweepStart = 1'b1;
        @(posedge clk);

        // Reset dominates requests
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Single decode
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Every index with in_valid held; in_sel scrambled while the PULSE_LEN=3 copy is driving
        for (int sel = 0; sel < 16; sel++) begin
            applyStimulus(1'b1, 1'b1, 4'(sel), 1'b0);
            for (int j = 0; j < 3; j++) applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
        end
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Sweep with a competing decode request held throughout
        applyStimulus(1'b1, 1'b1, 4'd9, 1'b1);
        repeat (56) applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Simultaneous sweep and decode in idle
        applyStimulus(1'b1, 1'b1, 4'd3, 1'b1);
        repeat (52) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Reset mid-sweep, then decode index 0
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 59) != 0), 1'($urandom % 2),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 29) == 0));
        end
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
